config_field_editor: RTL and testbench

//  Parametrised clock/date/timer field editor on the PicoBlaze output-port bus.

---
 rtl/config_field_editor.sv | 231 +++++++++++++++++++++++
 tb/tb_config_field_editor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/config_field_editor.sv
// ---------------------------------------------------------------------------
// config_field_editor
//
// Purpose:
//   Field editor for clock, date and timer settings, driven from the
//   PicoBlaze output-port bus. It holds nine 2-digit BCD fields.
//   Cursor and key commands step the selected field up or down. Each field
//   wraps at its own range, and every digit stays valid BCD. Direct preload
//   ports let firmware, or an RTC readback, write a field. A preload is
//   accepted only when it is valid BCD and inside the field's range. DAY is
//   kept within the length of the current month.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_dato, port_id        PicoBlaze out_port data and port address
//   write_strobe            OUTPUT strobe
//   k_write_strobe          OUTPUTK strobe (same meaning as write_strobe)
//   btn_data_*              nine registered BCD field values
//   cursor_location         selected field within the current mode (0..2)
//   config_mode             0 normal, 1 time, 2 date, 3 timer
//   field_changed           one-cycle pulse, set in the cycle a new field
//                           value becomes visible
//   load_err                one-cycle pulse after a rejected preload
//
// Bus handshake: there is no back-pressure. A write is a one-cycle strobe
// (write_strobe | k_write_strobe) that is sampled on each posedge. Its effect
// is visible on the registered outputs in the following cycle.
// ---------------------------------------------------------------------------
module config_field_editor #(
    parameter logic [7:0] CMD_PORT  = 8'h11,
    parameter logic [7:0] LOAD_BASE = 8'h20,
    parameter bit         DAY_CLAMP = 1'b1,
    parameter logic [7:0] YEAR_RST  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_dato,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       k_write_strobe,
    output logic [7:0] btn_data_SS,
    output logic [7:0] btn_data_MM,
    output logic [7:0] btn_data_HH,
    output logic [7:0] btn_data_YEAR,
    output logic [7:0] btn_data_MES,
    output logic [7:0] btn_data_DAY,
    output logic [7:0] btn_data_SS_T,
    output logic [7:0] btn_data_MM_T,
    output logic [7:0] btn_data_HH_T,
    output logic [1:0] cursor_location,
    output logic [1:0] config_mode,
    output logic       field_changed,
    output logic       load_err
);

    // Field indices, which are also the preload port offsets.
    localparam logic [3:0] F_SS   = 4'd0;
    localparam logic [3:0] F_MM   = 4'd1;
    localparam logic [3:0] F_HH   = 4'd2;
    localparam logic [3:0] F_YEAR = 4'd3;
    localparam logic [3:0] F_MES  = 4'd4;
    localparam logic [3:0] F_DAY  = 4'd5;
    localparam logic [3:0] F_SS_T = 4'd6;
    localparam logic [3:0] F_MM_T = 4'd7;
    localparam logic [3:0] F_HH_T = 4'd8;

    localparam logic [1:0] KEY_RIGHT = 2'b00;
    localparam logic [1:0] KEY_UP    = 2'b01;
    localparam logic [1:0] KEY_DOWN  = 2'b10;
    localparam logic [1:0] KEY_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_TIME   = 2'd1,
        MODE_DATE   = 2'd2,
        MODE_TIMER  = 2'd3
    } mode_t;

    logic [8:0][7:0] fields_q, fields_d;
    logic [1:0]      cursor_q, cursor_d;
    mode_t           mode_q, mode_d;
    logic            field_changed_q, field_changed_d;
    logic            load_err_q, load_err_d;

    logic       wr, cmd_hit, load_hit, load_ok, day_written;
    logic [7:0] load_off;
    logic [3:0] load_idx, sel_idx;
    logic [6:0] year_bin;
    logic       leap;
    logic [7:0] dim, day_max;

    // Lower limit of each field (BCD).
    function automatic logic [7:0] field_min(input logic [3:0] idx);
        return (idx == F_MES || idx == F_DAY) ? 8'h01 : 8'h00;
    endfunction

    // Upper limit of each field (BCD). The DAY limit depends on the month.
    function automatic logic [7:0] field_max(input logic [3:0] idx,
                                             input logic [7:0] dmax);
        logic [7:0] m;
        case (idx)
            F_HH, F_HH_T: m = 8'h23;
            F_YEAR:       m = 8'h99;
            F_MES:        m = 8'h12;
            F_DAY:        m = dmax;
            default:      m = 8'h59;
        endcase
        return m;
    endfunction

    // BCD +/-1 with wrap. A value outside [lo,hi] also wraps (up to lo,
    // down to hi). Valid BCD values compare correctly as plain bytes.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] r;
        if (up) begin
            if (v >= hi)              r = lo;
            else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
            else                      r = v + 8'd1;
        end else begin
            if (v <= lo)              r = hi;
            else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
            else                      r = v - 8'd1;
        end
        return r;
    endfunction

    always_comb begin
        wr       = write_strobe | k_write_strobe;
        cmd_hit  = wr && (port_id == CMD_PORT);
        load_off = port_id - LOAD_BASE;      // wraps large when below base
        load_hit = wr && (load_off < 8'd9);
        load_idx = load_off[3:0];

        // Leap year test on the binary value of YEAR (divisible by 4).
        year_bin = 7'(fields_q[F_YEAR][7:4]) * 7'd10 + 7'(fields_q[F_YEAR][3:0]);
        leap     = (year_bin[1:0] == 2'b00);
        case (fields_q[F_MES])
            8'h02:                      dim = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
            default:                    dim = 8'h31;
        endcase
        day_max = DAY_CLAMP ? dim : 8'h31;

        case (mode_q)
            MODE_TIME:  sel_idx = 4'(cursor_q);
            MODE_DATE:  sel_idx = 4'(cursor_q) + 4'd3;
            MODE_TIMER: sel_idx = 4'(cursor_q) + 4'd6;
            default:    sel_idx = 4'd0;
        endcase

        load_ok = (in_dato[7:4] <= 4'd9) && (in_dato[3:0] <= 4'd9) &&
                  (in_dato >= field_min(load_idx)) &&
                  (in_dato <= field_max(load_idx, day_max));

        fields_d    = fields_q;
        cursor_d    = cursor_q;
        mode_d      = mode_q;
        load_err_d  = 1'b0;
        day_written = 1'b0;

        if (cmd_hit) begin
            if (in_dato[4:3] != mode_q) begin
                // A mode switch resets the cursor. Any key in the same byte is dropped.
                mode_d   = mode_t'(in_dato[4:3]);
                cursor_d = 2'd0;
            end else if (in_dato[2] && mode_q != MODE_NORMAL) begin
                case (in_dato[1:0])
                    KEY_LEFT:  cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                    KEY_RIGHT: cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                    default: begin
                        fields_d[sel_idx] = bcd_step(fields_q[sel_idx],
                                                     in_dato[1:0] == KEY_UP,
                                                     field_min(sel_idx),
                                                     field_max(sel_idx, day_max));
                        day_written = (sel_idx == F_DAY);
                    end
                endcase
            end
        end else if (load_hit) begin
            if (load_ok) begin
                fields_d[load_idx] = in_dato;
                day_written        = (load_idx == F_DAY);
            end else begin
                load_err_d = 1'b1;
            end
        end

        // A MES or YEAR change can shorten the month. Pull DAY down to the
        // month length one edge later. An explicit DAY edit takes priority
        // in that cycle.
        if (DAY_CLAMP && !day_written && fields_q[F_DAY] > dim)
            fields_d[F_DAY] = dim;

        field_changed_d = (fields_d != fields_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fields_q         <= '0;
            fields_q[F_YEAR] <= YEAR_RST;
            fields_q[F_MES]  <= 8'h01;
            fields_q[F_DAY]  <= 8'h01;
            cursor_q         <= 2'd0;
            mode_q           <= MODE_NORMAL;
            field_changed_q  <= 1'b0;
            load_err_q       <= 1'b0;
        end else begin
            fields_q        <= fields_d;
            cursor_q        <= cursor_d;
            mode_q          <= mode_d;
            field_changed_q <= field_changed_d;
            load_err_q      <= load_err_d;
        end
    end

    assign btn_data_SS     = fields_q[F_SS];
    assign btn_data_MM     = fields_q[F_MM];
    assign btn_data_HH     = fields_q[F_HH];
    assign btn_data_YEAR   = fields_q[F_YEAR];
    assign btn_data_MES    = fields_q[F_MES];
    assign btn_data_DAY    = fields_q[F_DAY];
    assign btn_data_SS_T   = fields_q[F_SS_T];
    assign btn_data_MM_T   = fields_q[F_MM_T];
    assign btn_data_HH_T   = fields_q[F_HH_T];
    assign cursor_location = cursor_q;
    assign config_mode     = mode_q;
    assign field_changed   = field_changed_q;
    assign load_err        = load_err_q;

endmodule

// File: tb/tb_config_field_editor.sv
// ---------------------------------------------------------------------------
// tb_config_field_editor
//
// Directed bench for config_field_editor with its default parameters.
// Inputs change on the negedge. Outputs are sampled 1 time unit after the
// posedge that captured the write.
// ---------------------------------------------------------------------------
module tb_config_field_editor;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_dato;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       k_write_strobe;
    logic [7:0] ss, mm, hh, year, mes, day, ss_t, mm_t, hh_t;
    logic [1:0] cursor, mode;
    logic       fc, le;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    config_field_editor dut (
        .clk            (clk),
        .reset          (reset),
        .in_dato        (in_dato),
        .port_id        (port_id),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .btn_data_SS    (ss),
        .btn_data_MM    (mm),
        .btn_data_HH    (hh),
        .btn_data_YEAR  (year),
        .btn_data_MES   (mes),
        .btn_data_DAY   (day),
        .btn_data_SS_T  (ss_t),
        .btn_data_MM_T  (mm_t),
        .btn_data_HH_T  (hh_t),
        .cursor_location(cursor),
        .config_mode    (mode),
        .field_changed  (fc),
        .load_err       (le)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus write: it is captured on the next posedge, and the caller
    // samples the result 1 time unit later.
    task automatic bus_wr(input logic [7:0] p, input logic [7:0] d, input bit use_k);
        @(negedge clk);
        port_id        = p;
        in_dato        = d;
        write_strobe   = !use_k;
        k_write_strobe = use_k;
        @(posedge clk);
        #1;
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        in_dato        = 8'h00;
        port_id        = 8'h00;
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_ss", ss, 8'h00);
        check("rst_mm", mm, 8'h00);
        check("rst_hh", hh, 8'h00);
        check("rst_year", year, 8'h00);
        check("rst_mes", mes, 8'h01);
        check("rst_day", day, 8'h01);
        check("rst_ss_t", ss_t, 8'h00);
        check("rst_mm_t", mm_t, 8'h00);
        check("rst_hh_t", hh_t, 8'h00);
        check("rst_cursor", {6'd0, cursor}, 8'h00);
        check("rst_mode", {6'd0, mode}, 8'h00);
        check("rst_fc", {7'd0, fc}, 8'h00);
        check("rst_le", {7'd0, le}, 8'h00);

        // Step 1: enter mode 1, then UP on SS
        bus_wr(8'h11, 8'h08, 0);
        check("s1_mode", {6'd0, mode}, 8'h01);
        check("s1_cursor", {6'd0, cursor}, 8'h00);
        check("s1_fc_mode", {7'd0, fc}, 8'h00);
        bus_wr(8'h11, 8'h0D, 0);
        check("s1_ss_up", ss, 8'h01);
        check("s1_fc", {7'd0, fc}, 8'h01);
        idle();
        check("s1_fc_drop", {7'd0, fc}, 8'h00);

        // Step 2: 59 UP -> 00, 00 DOWN -> 59, BCD carry 09 -> 10
        bus_wr(8'h20, 8'h09, 0);
        check("s2_pre09", ss, 8'h09);
        bus_wr(8'h11, 8'h0D, 0);
        check("s2_carry", ss, 8'h10);
        bus_wr(8'h20, 8'h59, 0);
        check("s2_pre59", ss, 8'h59);
        check("s2_pre_fc", {7'd0, fc}, 8'h01);
        bus_wr(8'h11, 8'h0D, 0);
        check("s2_wrap_up", ss, 8'h00);
        check("s2_mm_same", mm, 8'h00);
        bus_wr(8'h11, 8'h0E, 0);
        check("s2_wrap_dn", ss, 8'h59);

        // Step 3: cursor moves, then a mode switch with a key in the same byte
        bus_wr(8'h11, 8'h0F, 0);
        check("s3_left1", {6'd0, cursor}, 8'h01);
        bus_wr(8'h11, 8'h0F, 0);
        check("s3_left2", {6'd0, cursor}, 8'h02);
        bus_wr(8'h11, 8'h0F, 0);
        check("s3_left0", {6'd0, cursor}, 8'h00);
        bus_wr(8'h11, 8'h0C, 0);
        check("s3_right", {6'd0, cursor}, 8'h02);
        bus_wr(8'h11, 8'h14, 0);
        check("s3_mode2", {6'd0, mode}, 8'h02);
        check("s3_cur0", {6'd0, cursor}, 8'h00);
        check("s3_ss_kept", ss, 8'h59);

        // Step 4: leap-year DAY range and clamp after a YEAR change
        bus_wr(8'h23, 8'h24, 0);
        check("s4_year", year, 8'h24);
        bus_wr(8'h24, 8'h02, 0);
        check("s4_mes", mes, 8'h02);
        bus_wr(8'h25, 8'h31, 0);
        check("s4_day31_le", {7'd0, le}, 8'h01);
        check("s4_day31_kept", day, 8'h01);
        bus_wr(8'h25, 8'h29, 0);
        check("s4_day29_le", {7'd0, le}, 8'h00);
        check("s4_day29", day, 8'h29);
        bus_wr(8'h11, 8'h15, 0);
        check("s4_year_up", year, 8'h25);
        check("s4_day_pre", day, 8'h29);
        idle();
        check("s4_day_clamp", day, 8'h28);
        check("s4_clamp_fc", {7'd0, fc}, 8'h01);
        idle();
        check("s4_fc_drop", {7'd0, fc}, 8'h00);
        // MES wrap: 12 UP -> 01, 01 DOWN -> 12
        bus_wr(8'h11, 8'h17, 0);
        check("s4_cur_mes", {6'd0, cursor}, 8'h01);
        bus_wr(8'h24, 8'h12, 0);
        bus_wr(8'h11, 8'h15, 0);
        check("s4_mes_up", mes, 8'h01);
        bus_wr(8'h11, 8'h16, 0);
        check("s4_mes_dn", mes, 8'h12);

        // Step 5: rejected preloads (non-BCD digit, out of range)
        bus_wr(8'h28, 8'h3A, 0);
        check("s5_hht_le", {7'd0, le}, 8'h01);
        check("s5_hht", hh_t, 8'h00);
        bus_wr(8'h22, 8'h24, 0);
        check("s5_hh_le", {7'd0, le}, 8'h01);
        check("s5_hh", hh, 8'h00);
        idle();
        check("s5_le_drop", {7'd0, le}, 8'h00);
        bus_wr(8'h30, 8'h55, 0);
        check("s5_other_fc", {7'd0, fc}, 8'h00);
        check("s5_other_le", {7'd0, le}, 8'h00);

        // Step 6: OUTPUTK strobe, keys ignored in mode 0, mid-run reset
        bus_wr(8'h11, 8'h00, 1);
        check("s6_mode0", {6'd0, mode}, 8'h00);
        bus_wr(8'h11, 8'h05, 1);
        check("s6_m0_ss", ss, 8'h59);
        check("s6_m0_fc", {7'd0, fc}, 8'h00);
        check("s6_m0_cur", {6'd0, cursor}, 8'h00);
        bus_wr(8'h21, 8'h45, 1);
        check("s6_k_mm", mm, 8'h45);
        check("s6_k_fc", {7'd0, fc}, 8'h01);
        reset = 1'b1;
        #1;
        check("s6_rst_fc", {7'd0, fc}, 8'h00);
        check("s6_rst_ss", ss, 8'h00);
        check("s6_rst_mm", mm, 8'h00);
        check("s6_rst_year", year, 8'h00);
        check("s6_rst_mes", mes, 8'h01);
        check("s6_rst_day", day, 8'h01);
        check("s6_rst_mode", {6'd0, mode}, 8'h00);
        check("s6_rst_cur", {6'd0, cursor}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        idle();
        check("s6_post_ss", ss, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
